// File: rtl/dvp_sensor_emulator.sv
// Raw 8-bit OmniVision-style DVP transmitter. It generates frame/line timing and
// deterministic test patterns on cmos_pclk, in place of a physical sensor.
`timescale 1ns/1ps
module dvp_sensor_emulator #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 144,
  parameter int V_ACTIVE  = 480,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [10:0] VS_LAST  = 11'(VS_LINES - 1);
  localparam logic [10:0] VBP_LAST = 11'(VBP_LINES - 1);
  localparam logic [10:0] ACT_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] VFP_LAST = 11'(VFP_LINES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [10:0] l_q, l_d;
  logic [1:0]  pat_q;
  logic        load_pat;
  logic        frame_end;
  logic [10:0] lines_last;

  logic        vsync_d, href_d, busy_d, done_d;
  logic [7:0]  data_d;

  // Next state and counters.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d   = state_q;
    h_d       = h_q;
    l_d       = l_q;
    load_pat  = 1'b0;
    frame_end = 1'b0;

    unique case (state_q)
      ST_VSYNC:  lines_last = VS_LAST;
      ST_VBP:    lines_last = VBP_LAST;
      ST_ACTIVE: lines_last = ACT_LAST;
      ST_VFP:    lines_last = VFP_LAST;
      default:   lines_last = '0;
    endcase

    if (state_q == ST_IDLE) begin
      h_d = '0;
      l_d = '0;
      if (enable) begin
        state_d  = ST_VSYNC;
        load_pat = 1'b1;
      end
    end else if (h_q == H_LAST) begin
      h_d = '0;
      if (l_q == lines_last) begin
        l_d = '0;
        unique case (state_q)
          ST_VSYNC:  state_d = ST_VBP;
          ST_VBP:    state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFP;
          ST_VFP: begin
            frame_end = 1'b1;
            if (enable) begin
              state_d  = ST_VSYNC;
              load_pat = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        l_d = l_q + 11'd1;
      end
    end else begin
      h_d = h_q + 12'd1;
    end
  end

  // NOTE: outputs decode the *next* state/counters so the registered pins line up
  // with the cycle they describe, with href and data sharing the same flop stage.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    vsync_d = (state_d == ST_VBP) || (state_d == ST_ACTIVE) || (state_d == ST_VFP);
    href_d  = (state_d == ST_ACTIVE) && (h_d < H_ACT);
    done_d  = (state_d == ST_VFP) && (h_d == H_LAST) && (l_d == VFP_LAST);
    data_d  = 8'h00;
    if (href_d) begin
      unique case (pat_q)
        2'd0: data_d = h_d[7:0];
        2'd1: data_d = l_d[7:0];
        2'd2: data_d = l_d[0] ? (h_d[0] ? 8'h10 : 8'h80) : (h_d[0] ? 8'h80 : 8'hF0);
        default: data_d = h_d[7:0] + l_d[7:0] + frame_cnt[7:0];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      h_q        <= '0;
      l_q        <= '0;
      pat_q      <= '0;
      frame_cnt  <= '0;
      dvp_vsync  <= 1'b0;
      dvp_href   <= 1'b0;
      dvp_data   <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      l_q        <= l_d;
      if (load_pat)  pat_q     <= pattern_sel;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      dvp_vsync  <= vsync_d;
      dvp_href   <= href_d;
      dvp_data   <= data_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: doc/dvp_sensor_emulator.md
# dvp_sensor_emulator

Synthesizable OmniVision-style DVP transmitter that drives cmos_vsync / cmos_href / cmos_data on cmos_pclk exactly as a raw 8-bit sensor would. It generates configurable frame/line timing and deterministic test patterns. It sits in the capture path's place of the physical sensor for simulation, bring-up and loopback, and feeds the DVP capture front end directly. Vsync polarity is high during the valid frame region and low during frame sync.

## Interface
Parameters:
- H_ACTIVE, 640: data bytes per active line (≥2)
- H_BLANK, 144: href-low cycles after each line (≥2); H_TOTAL = H_ACTIVE + H_BLANK
- V_ACTIVE, 480: active lines per frame (≥1)
- VS_LINES, 3: line periods with vsync low (frame sync, ≥1)
- VBP_LINES, 17: line periods with vsync high and href low, before the first active line (≥1)
- VFP_LINES, 10: line periods with vsync high and href low, after the last active line (≥1)

Ports:
- cmos_pclk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run request; sampled in IDLE and at end of frame
- pattern_sel  in  2  pattern select, latched at frame start
- dvp_vsync  out  1  frame valid (H) / frame sync (L)
- dvp_href  out  1  line data valid
- dvp_data  out  8  raw pixel byte
- busy  out  1  high whenever state ≠ IDLE
- frame_done  out  1  one-cycle pulse on last cycle of each frame
- frame_cnt  out  16  completed-frame count, wraps at 0xFFFF→0

## Operation
- States: IDLE, VSYNC, VBP, ACTIVE, VFP.
- Counters: h_cnt (12 b, 0..H_TOTAL-1) and l_cnt (11 b, line index within the current state). h_cnt wraps at H_TOTAL-1, and l_cnt then increments.
- IDLE: vsync=0, href=0, data=0. If enable=1, go to VSYNC with h_cnt=l_cnt=0, and latch pattern_sel into pat_q.
- VSYNC: vsync=0 for VS_LINES·H_TOTAL cycles, then VBP.
- VBP: vsync=1, href=0 for VBP_LINES·H_TOTAL cycles, then ACTIVE.
- ACTIVE: vsync=1 for V_ACTIVE·H_TOTAL cycles. href=1 while h_cnt < H_ACTIVE, else 0. After the last line, go to VFP.
- VFP: vsync=1, href=0 for VFP_LINES·H_TOTAL cycles. On its last cycle: frame_done=1 and frame_cnt+1. Then:
  - enable=1 → VSYNC (re-latch pattern_sel)
  - enable=0 → IDLE
- enable deasserted mid-frame has no effect until the frame completes; frames are never truncated.
- dvp_data = 0 whenever href=0. When href=1, with x = h_cnt and y = active line index:
  - pat 0: x[7:0]
  - pat 1: y[7:0]
  - pat 2: Bayer RGGB
    - y even, x even: 0xF0
    - y even, x odd: 0x80
    - y odd, x even: 0x80
    - y odd, x odd: 0x10
  - pat 3: (x + y + frame_cnt[7:0]) mod 256
- All outputs are flops. In any cycle, their value is the decode of the state/counters for that cycle: no extra pipeline lag between href and data.
- Frame length = (VS_LINES+VBP_LINES+V_ACTIVE+VFP_LINES)·H_TOTAL cycles. Back-to-back frames have no gap cycles.

## Timing
- Reset (async assert, sync release): state=IDLE; dvp_vsync=0, dvp_href=0, dvp_data=0x00, busy=0, frame_done=0, frame_cnt=0, pat_q=0.
- Frame start: enable high in IDLE at edge n → busy=1 from cycle n+1. vsync stays 0 (VSYNC state) through cycle n+VS_LINES·H_TOTAL.
- Vsync rises exactly VS_LINES·H_TOTAL cycles after busy rises.
- First href rise: VBP_LINES·H_TOTAL cycles after the vsync rise.
- href pulses: exactly H_ACTIVE cycles high, then H_BLANK cycles low.
- Last href fall: vsync stays high for H_BLANK + VFP_LINES·H_TOTAL more cycles, then falls, or returns to 0 in IDLE.
- frame_done is coincident with the last vsync-high cycle. frame_cnt shows the new value on the following cycle.
- Reset asserted mid-frame: all outputs go to reset values immediately; no partial frame completion.
- pattern_sel changes mid-frame are ignored until the next frame start.

## Test plan
- Small config (H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VS=VBP=VFP=1), pat 0, enable held:
  - frame = 84 cycles; vsync low 12 cycles, then high 72
  - 4 href pulses of 8 cycles, spaced 12
  - data 0..7 per line
  - frame_done every 84 cycles
- Same config, pat 2: per-line data alternates F0,80,… on even lines and 80,10,… on odd lines; data=0 outside href.
- pat 3 over 3 frames: first byte of line 0 = 0x00, 0x01, 0x02 in frames 0, 1, 2; frame_cnt reads 1, 2, 3 after each frame_done.
- Drop enable in the middle of line 2: frame runs to its full 84 cycles, then IDLE with busy=0 and vsync=0; no further href.
- Assert rst_n low during the ACTIVE state: outputs are 0 in the same cycle; after release with enable=1, a clean frame starts with vsync low for 12 cycles.
- Loopback into the DVP capture front end (wait count 2), pat 1: after the 3rd vsync fall, captured href/data match the emulator output delayed 2 cycles.
